// File: rtl/fpga_fabric.sv
// Island-style programmable fabric: 160 perimeter pins, 96 LUT4+FF cells and
// a full-crossbar router, all driven from a frame-loaded config memory.
// Optional macro FPGA_FABRIC_CFG_RST_EN: rst also clears the config memory.
module fpga_fabric #(
    parameter int NUM_FRAMES    = 245,
    parameter int FRAME_W       = 224,
    parameter int PINS_PER_SIDE = 40,
    parameter int NUM_CELLS     = 96
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [PINS_PER_SIDE-1:0] top_in,
    input  logic [PINS_PER_SIDE-1:0] bot_in,
    input  logic [PINS_PER_SIDE-1:0] left_in,
    input  logic [PINS_PER_SIDE-1:0] right_in,
    output logic [PINS_PER_SIDE-1:0] top_out,
    output logic [PINS_PER_SIDE-1:0] bot_out,
    output logic [PINS_PER_SIDE-1:0] left_out,
    output logic [PINS_PER_SIDE-1:0] right_out,
    input  logic                     ff_en,
    input  logic [NUM_FRAMES-1:0]    configs_en,
    input  logic [FRAME_W-1:0]       configs_in
);
    localparam int NUM_PINS    = 4 * PINS_PER_SIDE;
    localparam int SRC_W       = NUM_PINS + NUM_CELLS;
    localparam int CELL_W      = 56;
    localparam int PIN_W       = 16;
    localparam int OUT_BASE    = NUM_CELLS * CELL_W;
    localparam int CFG_USED    = OUT_BASE + NUM_PINS * PIN_W;
    // The used region is assumed to end part-way into a frame (7936 bits:
    // 35 full frames plus a 96-bit tail); everything beyond is reserved.
    localparam int FULL_FRAMES = CFG_USED / FRAME_W;
    localparam int TAIL        = CFG_USED - FULL_FRAMES * FRAME_W;
    localparam int USED_FRAMES = FULL_FRAMES + 1;

    logic [CFG_USED-1:0]  cfg;
    logic [NUM_CELLS-1:0] cell_ff;
    logic [NUM_CELLS-1:0] lut_out;
    logic [NUM_CELLS-1:0] cell_out;
    logic [NUM_PINS-1:0]  pin_out;
    logic [SRC_W-1:0]     src;
    logic                 unused_en;

    // Frame loader; every hot enable bit takes the same data word.
    always_ff @(posedge clock) begin
`ifdef FPGA_FABRIC_CFG_RST_EN
        if (rst) begin
            cfg <= '0;
        end else
`endif
        begin
            for (int f = 0; f < FULL_FRAMES; f++) begin
                if (configs_en[f]) cfg[f*FRAME_W +: FRAME_W] <= configs_in;
            end
            if (configs_en[FULL_FRAMES]) cfg[CFG_USED-1 -: TAIL] <= configs_in[TAIL-1:0];
        end
    end

    // Cell flip-flops: reset has priority, ff_en gates capture.
    always_ff @(posedge clock) begin
        if (rst)        cell_ff <= '0;
        else if (ff_en) cell_ff <= lut_out;
    end

    assign src       = {cell_out, right_in, left_in, bot_in, top_in};
    assign unused_en = ^configs_en[NUM_FRAMES-1:USED_FRAMES];

    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
        logic [CELL_W-1:0] cc;
        logic [15:0]       lut;
        logic [3:0]        idx;
        logic              unused_cell;
        assign cc          = cfg[c*CELL_W +: CELL_W];
        assign lut         = cc[15:0];
        assign idx         = {src[cc[47:40]], src[cc[39:32]], src[cc[31:24]], src[cc[23:16]]};
        assign lut_out[c]  = lut[idx];
        assign cell_out[c] = cc[48] ? cell_ff[c] : lut_out[c];
        assign unused_cell = ^cc[55:49];
    end

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [PIN_W-1:0] oc;
        logic             unused_pin;
        assign oc         = cfg[OUT_BASE + p*PIN_W +: PIN_W];
        assign pin_out[p] = oc[8] & src[oc[7:0]];
        assign unused_pin = ^oc[15:9];
    end

    assign top_out   = pin_out[0*PINS_PER_SIDE +: PINS_PER_SIDE];
    assign bot_out   = pin_out[1*PINS_PER_SIDE +: PINS_PER_SIDE];
    assign left_out  = pin_out[2*PINS_PER_SIDE +: PINS_PER_SIDE];
    assign right_out = pin_out[3*PINS_PER_SIDE +: PINS_PER_SIDE];

endmodule

// File: tb/tb_fpga_fabric.sv
// Directed bench for fpga_fabric: registered AND cell on top_out[0] and
// top_in[35] routed to right_out[20], [27] and [34].
module tb_fpga_fabric;
    logic         clock = 1'b0;
    logic         rst;
    logic [39:0]  top_in, bot_in, left_in, right_in;
    logic [39:0]  top_out, bot_out, left_out, right_out;
    logic         ff_en;
    logic [244:0] configs_en;
    logic [223:0] configs_in;

    int n_cmp  = 0;
    int n_fail = 0;

    fpga_fabric dut (
        .clock      (clock),
        .rst        (rst),
        .top_in     (top_in),
        .bot_in     (bot_in),
        .left_in    (left_in),
        .right_in   (right_in),
        .top_out    (top_out),
        .bot_out    (bot_out),
        .left_out   (left_out),
        .right_out  (right_out),
        .ff_en      (ff_en),
        .configs_en (configs_en),
        .configs_in (configs_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       t35;
        logic [1:0] t10;
        logic       ffe;
        logic       r;
        logic       exp_ff;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [223:0] rnd224();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [159:0] exp_pins(input logic ffv, input logic route);
        logic [159:0] e;
        e      = '0;
        e[0]   = ffv;
        e[140] = route;
        e[147] = route;
        e[154] = route;
        return e;
    endfunction

    task automatic check(input string name, input logic [159:0] exp);
        logic [159:0] got;
        got = {right_out, left_out, bot_out, top_out};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic write_frames(input logic [244:0] en, input logic [223:0] data);
        @(negedge clock);
        configs_en = en;
        configs_in = data;
        @(negedge clock);
        configs_en = '0;
        configs_in = rnd224();
    endtask

    logic prev_ff;
    logic [223:0] d;

    initial begin
        vecs[0]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; ff_en = 1'b0;
        top_in = '0; bot_in = '0; left_in = '0; right_in = '0;
        configs_en = '1; configs_in = '0;
        @(negedge clock);
        rst = 1'b0; configs_en = '0; configs_in = rnd224();
        top_in = 40'hFF_FFFF_FFFF; bot_in = $urandom; left_in = 40'hA5_5A5A_A5A5; right_in = '1;
        #1 check("reset_all_zero", '0);

        @(negedge clock);
        top_in = '0; bot_in = '0; left_in = '0; right_in = '0;
        // cell 0: LUT=in0&in1, sel0=pin0, sel1=pin1, registered
        write_frames(245'd1, 224'h0001_0000_0100_8888);
        // top_out[0]: sel=160 (cell 0), oe
        write_frames(245'd1 << 24, 224'h01A0);
        // frames 34 and 35 with one word: pins 140, 147, 154 <= pin 35
        d = '0;
        d[8:0]     = 9'h123;
        d[120:112] = 9'h123;
        write_frames((245'd1 << 34) | (245'd1 << 35), d);
        repeat (3) begin
            @(negedge clock);
            configs_in = rnd224();
        end
        #1 check("configured_idle", exp_pins(1'b0, 1'b0));

        // same-cycle combinational route
        @(negedge clock);
        top_in[35] = 1'b1;
        #1 check("route_comb_rise", exp_pins(1'b0, 1'b1));
        @(negedge clock);
        top_in[35] = 1'b0;
        #1 check("route_comb_fall", exp_pins(1'b0, 1'b0));

        prev_ff = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            top_in[35]  = vecs[i].t35;
            top_in[1:0] = vecs[i].t10;
            ff_en       = vecs[i].ffe;
            rst         = vecs[i].r;
            configs_in  = rnd224();
            #1 check($sformatf("vec%0d_pre", i), exp_pins(prev_ff, vecs[i].t35));
            @(posedge clock);
            #1 check($sformatf("vec%0d_post", i), exp_pins(vecs[i].exp_ff, vecs[i].t35));
            prev_ff = vecs[i].exp_ff;
        end

        // reset effect on config memory
        @(negedge clock);
        top_in[35] = 1'b1; top_in[1:0] = 2'b11; ff_en = 1'b0; rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
`ifdef FPGA_FABRIC_CFG_RST_EN
        #1 check("cfgrst_after_rst", '0);
`else
        #1 check("cfgrst_after_rst", exp_pins(1'b0, 1'b1));
`endif
        ff_en = 1'b1;
        @(posedge clock);
        #1;
`ifdef FPGA_FABRIC_CFG_RST_EN
        check("cfgrst_ff_on", '0);
`else
        check("cfgrst_ff_on", exp_pins(1'b1, 1'b1));
`endif
        @(negedge clock);
        top_in[35] = 1'b0;
        #1;
`ifdef FPGA_FABRIC_CFG_RST_EN
        check("cfgrst_toggle", '0);
`else
        check("cfgrst_toggle", exp_pins(1'b1, 1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
